// File: rtl/dp_mp_pkg.sv
// dp_mp_pkg: shared constants and types for the mixed-precision dot-product
// pipeline (dp_pipe_mp) and its per-lane multiplier (dp_mp_mul_lane).
//   - fp32/fp16 field widths and biases
//   - mode encodings (MODE_SINGLE / MODE_HALF)
//   - canonical NaN / infinity encodings
//   - product and per-beat stage structs
package dp_mp_pkg;

  localparam logic MODE_SINGLE = 1'b1;
  localparam logic MODE_HALF   = 1'b0;

  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F32_BIAS  = 127;
  localparam int F16_EXP_W = 5;
  localparam int F16_MAN_W = 10;
  localparam int F16_BIAS  = 15;

  // Product magnitudes share one 48-bit format with the binary point
  // after bit PT_POS; fp16 22-bit products are shifted up to match.
  localparam int PROD_W     = 2 * (F32_MAN_W + 1);
  localparam int F16_PROD_W = 2 * (F16_MAN_W + 1);
  localparam int PT_POS     = 2 * F32_MAN_W;
  localparam int EXP_W      = 11;

  // Exponent tag for zero products; below any real product exponent.
  localparam logic signed [EXP_W-1:0] EXP_NONE = {1'b1, {(EXP_W-1){1'b0}}};

  localparam logic [31:0] F32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] F32_INF  = 32'h7F80_0000;
  localparam logic [15:0] F16_QNAN = 16'h7E00;
  localparam logic [15:0] F16_INF  = 16'h7C00;

  typedef struct packed {
    logic                    sign;
    logic signed [EXP_W-1:0] exp;   // biased in the beat's own format
    logic [PROD_W-1:0]       mag;
  } prod_t;

  typedef struct packed {
    logic mode;
    logic nan;
  } meta_t;

  localparam prod_t PROD_ZERO = '{sign: 1'b0, exp: EXP_NONE, mag: '0};

endpackage

// File: rtl/dp_mp_mul_lane.sv
// dp_mp_mul_lane: unpacks one 32-bit x/y lane pair and multiplies.
//   i_mode  : 1 = fp32 (one product), 0 = packed fp16 (two products)
//   i_x/i_y : lane operands
//   o_prod  : [0] fp32 product or fp16 low-half product, [1] fp16 high half
//   o_nan   : some operand of this lane is inf/NaN
// Subnormals flush to zero (zero products carry exponent EXP_NONE).
module dp_mp_mul_lane
  import dp_mp_pkg::*;
(
  input  logic        i_mode,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output prod_t [1:0] o_prod,
  output logic        o_nan
);

  logic [F32_EXP_W-1:0]       w_xe, w_ye;
  logic                       w_z32, w_nan32;
  prod_t                      w_p32;
  logic [1:0][F16_EXP_W-1:0]  w_xe16, w_ye16;
  logic [1:0][F16_PROD_W-1:0] w_m16;
  logic [1:0]                 w_z16, w_nan16;
  prod_t [1:0]                w_p16;

  always_comb begin
    w_xe    = i_x[30:23];
    w_ye    = i_y[30:23];
    w_z32   = (w_xe == '0) || (w_ye == '0);
    w_nan32 = (w_xe == '1) || (w_ye == '1);
    w_p32.sign = i_x[31] ^ i_y[31];
    w_p32.exp  = w_z32 ? EXP_NONE
               : $signed({3'b0, w_xe}) + $signed({3'b0, w_ye}) - EXP_W'(F32_BIAS);
    w_p32.mag  = w_z32 ? '0 : {1'b1, i_x[22:0]} * {1'b1, i_y[22:0]};

    w_xe16 = '0; w_ye16 = '0; w_m16 = '0; w_z16 = '0; w_nan16 = '0; w_p16 = '0;
    for (int h = 0; h < 2; h++) begin
      w_xe16[h]  = i_x[16*h+10 +: 5];
      w_ye16[h]  = i_y[16*h+10 +: 5];
      w_z16[h]   = (w_xe16[h] == '0) || (w_ye16[h] == '0);
      w_nan16[h] = (w_xe16[h] == '1) || (w_ye16[h] == '1);
      w_m16[h]   = {1'b1, i_x[16*h +: 10]} * {1'b1, i_y[16*h +: 10]};
      w_p16[h].sign = i_x[16*h+15] ^ i_y[16*h+15];
      w_p16[h].exp  = w_z16[h] ? EXP_NONE
                    : $signed({6'b0, w_xe16[h]}) + $signed({6'b0, w_ye16[h]}) - EXP_W'(F16_BIAS);
      // MSB-align so both formats share the binary point at PT_POS
      w_p16[h].mag  = w_z16[h] ? '0 : {w_m16[h], {(PROD_W-F16_PROD_W){1'b0}}};
    end

    if (i_mode == MODE_SINGLE) begin
      o_prod[0] = w_p32;
      o_prod[1] = PROD_ZERO;
      o_nan     = w_nan32;
    end else begin
      o_prod    = w_p16;
      o_nan     = |w_nan16;
    end
  end

endmodule

// File: rtl/dp_pipe_mp.sv
// dp_pipe_mp: LANES-wide fp32 / packed-fp16 dot product, valid/ready with
// full-pipeline stall.
//   S1 unpack+multiply, S2 max-exponent align, S3 adder, S4 normalise/pack.
//   clk, rst (async, active high)
//   in_valid/in_ready/in_mode/in_x/in_y : operand beat
//   out_valid/out_ready/out_mode/result : result (fp16 in [15:0])
// Optional macro DP_PIPE_MP_ACC_EN: adds in_last and an accumulator stage
// that sums consecutive beats up to in_last (latency 5, one result/group).
module dp_pipe_mp
  import dp_mp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 52
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [32*LANES-1:0] in_x,
  input  logic [32*LANES-1:0] in_y,
`ifdef DP_PIPE_MP_ACC_EN
  input  logic               in_last,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [31:0]        result
);

  localparam int NP = 2 * LANES;
`ifdef DP_PIPE_MP_ACC_EN
  localparam int STAGES = 5;
  localparam int NW     = ACC_W + 4;
`else
  localparam int STAGES = 4;
  localparam int NW     = ACC_W;
`endif
  localparam int PW = $clog2(NW);

  logic                    w_adv;
  logic [STAGES:1]         r_vld_pipe;
  prod_t [NP-1:0]          w_prod;
  logic [LANES-1:0]        w_lane_nan;
  prod_t [NP-1:0]          r_s1_prod;
  meta_t                   r_s1_meta, r_s2_meta, r_s3_meta;
  logic signed [EXP_W-1:0] w_emax, r_s2_exp, r_s3_exp;
  logic [EXP_W:0]          w_sh;
  logic [PROD_W-1:0]       w_mag_sh;
  logic [NP-1:0][ACC_W-1:0] w_al, r_s2_al;
  logic signed [ACC_W-1:0] w_sum, r_s3_sum;
  logic [31:0]             r_result;
  logic                    r_out_mode;

  assign w_adv     = ~r_vld_pipe[STAGES] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[STAGES];
  assign result    = r_result;
  assign out_mode  = r_out_mode;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      dp_mp_mul_lane u_lane (
        .i_mode (in_mode),
        .i_x    (in_x[32*gi +: 32]),
        .i_y    (in_y[32*gi +: 32]),
        .o_prod (w_prod[2*gi +: 2]),
        .o_nan  (w_lane_nan[gi])
      );
    end
  endgenerate

  // S2: align every product to the largest exponent; bits shifted out drop
  always_comb begin
    w_emax = EXP_NONE;
    for (int i = 0; i < NP; i++)
      if ($signed(r_s1_prod[i].exp) > w_emax) w_emax = r_s1_prod[i].exp;
    w_sh = '0; w_mag_sh = '0; w_al = '0;
    for (int i = 0; i < NP; i++) begin
      w_sh     = {w_emax[EXP_W-1], w_emax} - {r_s1_prod[i].exp[EXP_W-1], r_s1_prod[i].exp};
      w_mag_sh = (w_sh >= (EXP_W+1)'(PROD_W)) ? '0 : r_s1_prod[i].mag >> w_sh;
      w_al[i]  = r_s1_prod[i].sign ? -{{(ACC_W-PROD_W){1'b0}}, w_mag_sh}
                                   :  {{(ACC_W-PROD_W){1'b0}}, w_mag_sh};
    end
  end

  // S3: signed sum; ACC_W leaves headroom for 2*LANES full-scale products
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NP; i++) w_sum = w_sum + $signed(r_s2_al[i]);
  end

`ifdef DP_PIPE_MP_ACC_EN
  logic [3:1]              r_last_pipe;
  logic signed [NW-1:0]    r_acc, r_s4_sum, w_cmb, w_s3_ext;
  logic signed [EXP_W-1:0] r_acc_exp, r_s4_exp, w_cmb_exp;
  logic                    r_acc_mode, r_acc_nan, r_acc_busy, r_s4_mode, r_s4_nan, w_cmb_nan;
  logic [EXP_W:0]          w_sa, w_sb;

  // Merge the incoming beat sum into the running group sum at the larger
  // of the two exponents.
  always_comb begin
    w_s3_ext  = NW'(r_s3_sum);
    w_cmb     = w_s3_ext;
    w_cmb_exp = r_s3_exp;
    w_cmb_nan = r_s3_meta.nan;
    w_sa = '0; w_sb = '0;
    if (r_acc_busy) begin
      if (r_acc_exp > r_s3_exp) w_cmb_exp = r_acc_exp;
      w_sa      = {w_cmb_exp[EXP_W-1], w_cmb_exp} - {r_acc_exp[EXP_W-1], r_acc_exp};
      w_sb      = {w_cmb_exp[EXP_W-1], w_cmb_exp} - {r_s3_exp[EXP_W-1], r_s3_exp};
      w_cmb     = (r_acc >>> w_sa) + (w_s3_ext >>> w_sb);
      w_cmb_nan = r_s3_meta.nan | r_acc_nan | (r_acc_mode != r_s3_meta.mode);
    end
  end
`endif

  // Final stage: normalise, truncate, pack
  logic signed [NW-1:0]    w_n_sum;
  logic signed [EXP_W-1:0] w_n_exp;
  logic                    w_n_mode, w_n_nan, w_s;
  logic [NW-1:0]           w_abs, w_norm;
  logic [PW-1:0]           w_p;
  logic signed [15:0]      w_e;
  logic [31:0]             w_res;

`ifdef DP_PIPE_MP_ACC_EN
  assign w_n_sum = r_s4_sum;  assign w_n_exp = r_s4_exp;
  assign w_n_mode = r_s4_mode; assign w_n_nan = r_s4_nan;
`else
  assign w_n_sum = r_s3_sum;  assign w_n_exp = r_s3_exp;
  assign w_n_mode = r_s3_meta.mode; assign w_n_nan = r_s3_meta.nan;
`endif

  always_comb begin
    w_s   = w_n_sum[NW-1];
    w_abs = w_s ? -w_n_sum : w_n_sum;
    w_p   = '0;
    for (int i = 0; i < NW; i++) if (w_abs[i]) w_p = PW'(i);
    w_norm = w_abs << (PW'(NW-1) - w_p);
    // value = abs * 2^-PT_POS * 2^(emax-bias), so biased result exponent
    // is p - PT_POS + emax in either format
    w_e = $signed({{(16-PW){1'b0}}, w_p}) + $signed({{(16-EXP_W){w_n_exp[EXP_W-1]}}, w_n_exp})
        - 16'(PT_POS);
    w_res = '0;
    if (w_n_nan)
      w_res = (w_n_mode == MODE_SINGLE) ? F32_QNAN : {16'h0, F16_QNAN};
    else if (w_abs == '0)
      w_res = '0;
    else if (w_n_mode == MODE_SINGLE) begin
      if (w_e >= 16'sd255)   w_res = {w_s, F32_INF[30:0]};
      else if (w_e <= 16'sd0) w_res = {w_s, 31'h0};
      else                   w_res = {w_s, w_e[7:0], w_norm[NW-2 -: 23]};
    end else begin
      if (w_e >= 16'sd31)    w_res = {16'h0, w_s, F16_INF[14:0]};
      else if (w_e <= 16'sd0) w_res = {16'h0, w_s, 15'h0};
      else                   w_res = {16'h0, w_s, w_e[4:0], w_norm[NW-2 -: 10]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_s1_prod  <= '0;  r_s1_meta <= '0;
      r_s2_al    <= '0;  r_s2_exp  <= '0;  r_s2_meta <= '0;
      r_s3_sum   <= '0;  r_s3_exp  <= '0;  r_s3_meta <= '0;
      r_result   <= '0;  r_out_mode <= 1'b0;
`ifdef DP_PIPE_MP_ACC_EN
      r_last_pipe <= '0;
      r_acc <= '0; r_acc_exp <= '0; r_acc_mode <= 1'b0; r_acc_nan <= 1'b0; r_acc_busy <= 1'b0;
      r_s4_sum <= '0; r_s4_exp <= '0; r_s4_mode <= 1'b0; r_s4_nan <= 1'b0;
`endif
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      r_s1_prod  <= w_prod;
      r_s1_meta  <= '{mode: in_mode, nan: |w_lane_nan};
      r_s2_al    <= w_al;
      r_s2_exp   <= w_emax;
      r_s2_meta  <= r_s1_meta;
      r_s3_sum   <= w_sum;
      r_s3_exp   <= r_s2_exp;
      r_s3_meta  <= r_s2_meta;
      r_result   <= w_res;
      r_out_mode <= w_n_mode;
`ifdef DP_PIPE_MP_ACC_EN
      r_last_pipe   <= {r_last_pipe[2:1], in_last};
      // only the closing beat of a group moves on to the output stage
      r_vld_pipe[4] <= r_vld_pipe[3] & r_last_pipe[3];
      if (r_vld_pipe[3]) begin
        if (r_last_pipe[3]) begin
          r_s4_sum   <= w_cmb;  r_s4_exp <= w_cmb_exp;
          r_s4_mode  <= r_s3_meta.mode; r_s4_nan <= w_cmb_nan;
          r_acc      <= '0;
          r_acc_busy <= 1'b0;
        end else begin
          r_acc      <= w_cmb;  r_acc_exp <= w_cmb_exp;
          r_acc_mode <= r_s3_meta.mode; r_acc_nan <= w_cmb_nan;
          r_acc_busy <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_dp_pipe_mp.sv
// tb_dp_pipe_mp: directed checks of dp_pipe_mp (LANES = 4) with
// hand-computed expected results.
module tb_dp_pipe_mp;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [127:0] in_x, in_y;
  logic [31:0]  result;
`ifdef DP_PIPE_MP_ACC_EN
  logic         in_last;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dp_pipe_mp #(.LANES(4), .ACC_W(52)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y),
`ifdef DP_PIPE_MP_ACC_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .result(result)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one beat, then wait (bounded) for its result with out_ready = 1.
  task automatic run_beat(input string tag, input logic m, input logic [127:0] x,
                          input logic [127:0] y, input logic [31:0] er, input int lat);
    int n;
    in_mode = m; in_x = x; in_y = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin tick(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_res"}, result, er);
    chk({tag, "_mode"}, {31'b0, out_mode}, {31'b0, m});
    tick();
  endtask

  logic [127:0] bx [6];
  logic [127:0] by [6];
  logic         bm [6];
  logic [31:0]  br [6];

  initial begin
    int  k, j, stall, cyc, seen;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mode = 1'b0; in_x = '0; in_y = '0;
`ifdef DP_PIPE_MP_ACC_EN
    in_last = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_mode", {31'b0, out_mode}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_inready", {31'b0, in_ready}, 32'd1);

`ifdef DP_PIPE_MP_ACC_EN
    // 3 beats of 4.0 each, last flagged on the third -> 12.0
    seen = 0;
    in_mode = 1'b1; in_x = {4{32'h3F80_0000}}; in_y = {4{32'h3F80_0000}}; in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2);
      tick();
      if (out_valid) seen++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    k = 1;
    while (!out_valid && k < 12) begin tick(); k++; end
    chk("acc_lat", 32'(k), 32'd5);
    chk("acc_res", result, 32'h4140_0000);
    chk("acc_early", 32'(seen), 32'd0);
`else
    run_beat("f32_ones", 1'b1, {4{32'h3F80_0000}}, {4{32'h3F80_0000}}, 32'h4080_0000, 4);
    run_beat("f16_ones", 1'b0, {4{32'h3C00_3C00}}, {4{32'h3C00_3C00}}, 32'h0000_4800, 4);
    run_beat("cancel", 1'b1, {64'h0, 32'hC000_0000, 32'h4000_0000},
             {64'h0, 32'h4040_0000, 32'h4040_0000}, 32'h0, 4);
    run_beat("nan_inf", 1'b1, {32'h0, 32'h7F80_0000, 64'h0}, {4{32'h3F80_0000}}, 32'h7FC0_0000, 4);
    run_beat("nan_f16", 1'b0, {96'h0, 32'h3C00_7E00}, {4{32'h3C00_3C00}}, 32'h0000_7E00, 4);
    run_beat("neg", 1'b1, {96'h0, 32'hBFC0_0000}, {96'h0, 32'h4000_0000}, 32'hC040_0000, 4);
    run_beat("mix16", 1'b0, {96'h0, 32'h3C00_4000}, {96'h0, 32'h4200_3C00}, 32'h0000_4500, 4);
    run_beat("trunc", 1'b1, {96'h0, 32'h3F80_0001}, {96'h0, 32'h3F80_0001}, 32'h3F80_0002, 4);
    run_beat("subn", 1'b1, {64'h0, 32'h3F80_0000, 32'h0000_0001},
             {64'h0, 32'h3F80_0000, 32'h3F80_0000}, 32'h3F80_0000, 4);
    run_beat("undf", 1'b1, {96'h0, 32'h0080_0000}, {96'h0, 32'h0080_0000}, 32'h0, 4);
    run_beat("ovf32", 1'b1, {4{32'hFF00_0000}}, {4{32'h7F00_0000}}, 32'hFF80_0000, 4);
    run_beat("ovf16", 1'b0, {4{32'h7BFF_7BFF}}, {4{32'h7BFF_7BFF}}, 32'h0000_7C00, 4);

    // Backpressure: 6 interleaved-mode beats, out_ready low 3 cycles
    bm[0] = 1'b1; bx[0] = {4{32'h3F80_0000}}; by[0] = {4{32'h3F80_0000}}; br[0] = 32'h4080_0000;
    bm[1] = 1'b0; bx[1] = {4{32'h3C00_3C00}}; by[1] = {4{32'h3C00_3C00}}; br[1] = 32'h0000_4800;
    bm[2] = 1'b1; bx[2] = {96'h0, 32'hBFC0_0000}; by[2] = {96'h0, 32'h4000_0000}; br[2] = 32'hC040_0000;
    bm[3] = 1'b0; bx[3] = {96'h0, 32'h3C00_4000}; by[3] = {96'h0, 32'h4200_3C00}; br[3] = 32'h0000_4500;
    bm[4] = 1'b1; bx[4] = {96'h0, 32'h3F80_0001}; by[4] = {96'h0, 32'h3F80_0001}; br[4] = 32'h3F80_0002;
    bm[5] = 1'b1; bx[5] = {64'h0, 32'hC000_0000, 32'h4000_0000};
                  by[5] = {64'h0, 32'h4040_0000, 32'h4040_0000}; br[5] = 32'h0;
    k = 0; j = 0; stall = 0; cyc = 0;
    while (j < 6 && cyc < 60) begin
      if (out_valid && stall < 3) begin out_ready = 1'b0; stall++; end
      else out_ready = 1'b1;
      in_valid = (k < 6);
      if (k < 6) begin in_mode = bm[k]; in_x = bx[k]; in_y = by[k]; end
      #1;
      if (!out_ready) begin
        chk("bp_hold", result, br[j]);
        chk("bp_inready", {31'b0, in_ready}, 32'd0);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_res%0d", j), result, br[j]);
        chk($sformatf("bp_mode%0d", j), {31'b0, out_mode}, {31'b0, bm[j]});
        j++;
      end
      acc = in_valid && (!out_valid || out_ready);
      tick();
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 32'(j), 32'd6);
    seen = 0;
    repeat (4) begin tick(); if (out_valid) seen++; end
    chk("bp_nodup", 32'(seen), 32'd0);

    // Reset with 3 beats in flight discards them
    in_mode = 1'b1; in_x = {4{32'h3F80_0000}}; in_y = {4{32'h3F80_0000}}; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (6) begin tick(); if (out_valid) seen++; end
    chk("rst_flush", 32'(seen), 32'd0);
    run_beat("post_rst", 1'b1, {4{32'h3F80_0000}}, {4{32'h3F80_0000}}, 32'h4080_0000, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_pipe_mp.md
Name: dp_pipe_mp

Overview:
- Parametrised successor to the fixed 4-lane dot-product pipeline: computes sum(x[i]*y[i]) over LANES lanes.
- Operates in fp32 mode or packed-fp16 mode; in fp16 mode each lane carries two halves, giving 2*LANES products.
- Adds valid/ready flow control with full-pipeline stall and an explicit mode input carried per beat (no mode inference from data).
- Sits between the operand fetch buffer and the result writeback FIFO.

Parameters:
- LANES, 4, number of 32-bit operand lanes per beat; power of two, 2..16
- ACC_W, 52, internal signed fixed-point sum width after alignment (must be >= 48 + log2(2*LANES) + 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- in_mode  in  1  1 = fp32, 0 = packed fp16 ([31:16] high half, [15:0] low half)
- in_x  in  32*LANES  x operands, lane i at [32i+31:32i]
- in_y  in  32*LANES  y operands, same packing
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_mode  out  1  mode of the beat in result
- result  out  32  fp32 result; in fp16 mode fp16 in [15:0], [31:16] = 0

Behaviour:
- Reset: clock and reset as already decided (single clock clk; asynchronous active-high rst). All stage valids = 0, out_valid = 0, result = 0, out_mode = 0. Asserting rst mid-operation discards all in-flight beats; no output follows.
- Pipeline: 4 register stages.
  - S1: unpack + mantissa multiply.
  - S2: max-exponent search, products aligned right to max exponent; shifted-out bits dropped.
  - S3: signed adder tree over all products.
  - S4: normalise, round, pack.
- Latency: exactly 4 cycles from accepted beat to out_valid when unstalled; throughput 1 beat/cycle.
- Flow control:
  - adv = ~out_valid | out_ready; in_ready = adv.
  - All stages shift only when adv = 1; in_valid is ignored when in_ready = 0.
  - Bubbles are not collapsed.
- Holding rule: while out_valid = 1 and out_ready = 0, result and out_mode are held stable.
- Mode is per beat and travels with its data; fp32 and fp16 beats may be interleaved back-to-back.
- Operand and result handling:
  - Subnormal inputs are flushed to zero.
  - Any input with exponent all-ones (inf/NaN) makes the beat's result canonical NaN: fp32 32'h7FC00000, fp16 16'h7E00.
  - Exact-zero sum gives +0.
  - Rounding: truncate toward zero.
  - Exponent overflow saturates to signed infinity (32'h7F800000 / 16'h7C00); underflow flushes to signed zero.
- Widths:
  - fp32 product = 48-bit magnitude, exponent = ex + ey - 127.
  - fp16 product = 22-bit magnitude placed MSB-aligned in the same datapath, exponent bias 15.
  - The adder tree uses ACC_W bits signed and never overflows for the permitted LANES.

Optional Feature:
- Macro: DP_PIPE_MP_ACC_EN
- When defined:
  - Adds input in_last (1 bit, qualified by in_valid).
  - An S5 accumulator (ACC_W+4 bits, aligned to a running max exponent) sums consecutive beats.
  - out_valid asserts only for the beat carrying in_last = 1; the accumulator then clears.
  - A mode change mid-group forces a NaN result for that group.
  - Latency becomes 5.
  - rst clears the accumulator.
- When undefined: no in_last port; every beat produces a result.

Decomposition:
- Package dp_mp_pkg:
  - format field widths and biases for fp32/fp16
  - mode encodings MODE_SINGLE = 1'b1, MODE_HALF = 1'b0
  - canonical NaN/inf constants
  - stage struct typedefs (sign, exp, magnitude, valid, mode)
- One sub-module, dp_mp_mul_lane: unpacks one 32-bit lane pair and produces either one fp32 product or two fp16 products. Instantiated LANES times.

Test Plan:
- fp32, LANES = 4, all x = y = 32'h3F800000, out_ready = 1 → result 32'h40800000 exactly 4 cycles after acceptance, out_mode = 1.
- fp16, all lanes x = y = 32'h3C003C00 → result 32'h00004800 (8.0), out_mode = 0.
- fp32 cancellation: x0 = 2.0, y0 = 3.0, x1 = -2.0, y1 = 3.0, others 0 → result 32'h00000000.
- Backpressure: 6 back-to-back beats, out_ready held low for 3 cycles once out_valid rises → result held stable, in_ready = 0, all 6 results delivered in order with no loss or duplication.
- x2 = 32'h7F800000 → 32'h7FC00000; separately, rst pulsed with 3 beats in flight → out_valid stays 0 until new beats arrive.
- With DP_PIPE_MP_ACC_EN: 3 fp32 beats of all-1.0 operands, in_last on the third → single result 32'h41400000 (12.0), 5 cycles after the last beat.
